// File: rtl/serial_fa_sequencer.sv
// Bit-serial add sequencer around a pipelined single-bit full adder.
// Optional subtract mode enabled by defining SERIAL_FA_SUB_EN.
module serial_fa_sequencer #(
    parameter int WIDTH  = 8,
    parameter int FA_LAT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_FA_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // state | meaning
    // FLUSH | drain adder pipeline after reset, FA_LAT cycles
    // IDLE  | waiting for operands
    // ISSUE | drive one bit pair plus carry into the adder
    // WAIT  | count down adder latency, sample sum/carry at zero
    // DONE  | result presented until consumer takes it
    localparam logic [2:0] FLUSH = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (FA_LAT > 1) ? $clog2(FA_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FA_LAT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            cnt       <= CNT_INIT;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        idx   <= '0;
                        state <= ISSUE;
`ifdef SERIAL_FA_SUB_EN
                        // two's-complement subtract: invert B, force carry-in
                        b_reg     <= sub ? ~op_b : op_b;
                        carry_reg <= sub ? 1'b1 : cin;
`else
                        b_reg     <= op_b;
                        carry_reg <= cin;
`endif
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        sum[idx]  <= fa_s;
                        carry_reg <= fa_cout;
                        if (idx == LAST_IDX) begin
                            cout  <= fa_cout;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fa_a      = (state == ISSUE) & a_reg[idx];
    assign fa_b      = (state == ISSUE) & b_reg[idx];
    assign fa_c      = (state == ISSUE) & carry_reg;

endmodule

// File: doc/serial_fa_sequencer.md
Name: serial_fa_sequencer

Overview:
- Bit-serial add controller wrapped around the path-balanced full-adder stage. It feeds that stage's a/b/c inputs and consumes its s/cout outputs.
- Accepts two WIDTH-bit operands over a valid/ready handshake and issues them LSB-first, one bit per adder pass.
- Carry is fed back from cout to c between passes. Sum bits are collected into a result word that is returned over a second valid/ready handshake.
- Used to build multi-bit adders from the single balanced full-adder cell without replicating it.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >=1.
- FA_LAT, 8, clock cycles from fa_a/fa_b/fa_c issue until fa_s/fa_cout are valid. Equals the balanced adder's logic depth; legal range >=1.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- cin  in  1  carry-in for bit 0
- fa_a  out  1  adder input a (pulse)
- fa_b  out  1  adder input b (pulse)
- fa_c  out  1  adder input c (pulse)
- fa_s  in  1  adder sum output
- fa_cout  in  1  adder carry output
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result bits
- cout  out  1  final carry-out

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: in_ready=0, fa_a=fa_b=fa_c=0, out_valid=0, sum=0, cout=0. FSM state is FLUSH.
- FSM states: FLUSH, IDLE, ISSUE, WAIT, DONE.
- FLUSH:
  - Entered on reset.
  - Holds for FA_LAT cycles (down-counter), then goes to IDLE.
  - Drains pulses still in flight in the adder pipeline if reset lands mid-operation.
  - fa_s/fa_cout are ignored in FLUSH.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a, op_b; carry_reg=cin; idx=0; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - fa_a=a_reg[idx], fa_b=b_reg[idx], fa_c=carry_reg.
  - Start wait counter at FA_LAT-1; go to WAIT.
  - fa_* are 0 in every other state.
- WAIT:
  - Decrement the counter.
  - In the cycle the counter reaches 0 (exactly FA_LAT cycles after the ISSUE cycle), sample: sum[idx]<=fa_s, carry_reg<=fa_cout.
  - If idx==WIDTH-1: cout<=fa_cout, go to DONE. Else idx++ and go to ISSUE.
  - For FA_LAT=1, WAIT lasts one cycle.
- DONE:
  - out_valid=1; sum and cout held stable until out_ready=1.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - in_ready=0 in DONE, so the earliest new acceptance is the cycle after the handoff.
- Timing:
  - Per-bit cost is FA_LAT+1 cycles.
  - With acceptance in cycle 0, out_valid rises in cycle WIDTH*(FA_LAT+1)+1; with defaults that is cycle 73.
- Busy/idle rules:
  - in_ready=0 in all states except IDLE; in_valid there is ignored and operands are not sampled.
  - fa_s/fa_cout outside the WAIT sample cycle are ignored.
- Arithmetic: {cout,sum} = op_a + op_b + cin, mod 2^(WIDTH+1). The block performs no adder arithmetic itself.
- Reset mid-operation:
  - Discards the operation; sum/cout clear to 0.
  - Goes to FLUSH, and no result is produced.

Optional Feature:
- Macro SERIAL_FA_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), latched with the operands on acceptance.
  - sub=1: b_reg is loaded with ~op_b, carry_reg is loaded with 1, and cin is ignored. Result is op_a - op_b mod 2^WIDTH.
  - cout=1 means no borrow.
  - sub=0: identical to the base behaviour.
- When undefined: no sub port; addition only.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst 3 cycles, release.
  - Required: in_ready=0 for FA_LAT=8 cycles, then 1.
  - Required: fa_*, out_valid, sum, cout stay 0 throughout.
- Basic add (bench models the adder as an 8-cycle delay line of a+b+c):
  - Stimulus: op_a=0x5A, op_b=0x33, cin=0.
  - Required: out_valid in cycle 73; sum=0x8D, cout=0.
  - Required: exactly 8 ISSUE pulses, spaced 9 cycles apart.
- Full carry ripple:
  - Stimulus: op_a=0xFF, op_b=0x00, cin=1.
  - Required: sum=0x00, cout=1.
  - Required: fa_c=1 on all 8 issues.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; pulse in_valid with new operands during that time.
  - Required: sum/cout unchanged, in_ready=0, new operands not taken.
  - Required: after out_ready, new op accepted no earlier than 1 cycle later.
- Reset mid-operation:
  - Stimulus: assert rst during bit 4 WAIT. Bench adder keeps emitting fa_s=1, fa_cout=1 for 8 more cycles. Then run op_a=0x01, op_b=0x01, cin=0.
  - Required: no out_valid for the aborted op; the new result is sum=0x02, cout=0, with stale pulses having no effect.
- SERIAL_FA_SUB_EN defined:
  - Stimulus: op_a=0x10, op_b=0x01, sub=1.
  - Required: sum=0x0F, cout=1.
  - Stimulus: op_a=0x01, op_b=0x02, sub=1.
  - Required: sum=0xFF, cout=0.
